// File: rtl/md_pkg.sv
// Shared definitions for the E-stage multiply/divide unit.
// Holds the MD opcode encodings, the FSM states and the default latencies.
package md_pkg;

  localparam int unsigned MD_XLEN = 32;
  localparam int unsigned MD_CNT_W = 4;
  localparam int unsigned MD_MULT_CYCLES_DEF = 5;
  localparam int unsigned MD_DIV_CYCLES_DEF = 10;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

endpackage

// File: rtl/md_divider.sv
// Combinational quotient/remainder for DIV/DIVU.
// Signed results truncate toward zero; the remainder follows the dividend's sign.
module md_divider
  import md_pkg::*;
(
  input  logic [MD_XLEN-1:0] dividend,
  input  logic [MD_XLEN-1:0] divisor,
  input  logic               is_signed,
  output logic [MD_XLEN-1:0] quotient,
  output logic [MD_XLEN-1:0] remainder,
  output logic               div_by_zero
);

  logic               neg_a;
  logic               neg_b;
  logic [MD_XLEN-1:0] mag_a;
  logic [MD_XLEN-1:0] mag_b;
  logic [MD_XLEN-1:0] safe_b;
  logic [MD_XLEN-1:0] q_mag;
  logic [MD_XLEN-1:0] r_mag;

  always_comb begin
    neg_a       = is_signed & dividend[MD_XLEN-1];
    neg_b       = is_signed & divisor[MD_XLEN-1];
    mag_a       = neg_a ? (~dividend + 1'b1) : dividend;
    mag_b       = neg_b ? (~divisor + 1'b1) : divisor;
    div_by_zero = (divisor == '0);
    // Keep the operator defined on /0; the caller discards the result anyway.
    safe_b      = div_by_zero ? {{(MD_XLEN-1){1'b0}}, 1'b1} : mag_b;
    q_mag       = mag_a / safe_b;
    r_mag       = mag_a % safe_b;
    quotient    = (neg_a ^ neg_b) ? (~q_mag + 1'b1) : q_mag;
    remainder   = neg_a ? (~r_mag + 1'b1) : r_mag;
  end

endmodule

// File: rtl/e_stage_mdu.sv
// E-stage multiply/divide unit owning HI/LO.
// Results are computed at the start edge and committed after a fixed latency.
module e_stage_mdu
  import md_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [2:0]         md_op,
  input  logic [MD_XLEN-1:0] rs_val,
  input  logic [MD_XLEN-1:0] rt_val,
  output logic               busy,
  output logic [MD_XLEN-1:0] hi,
  output logic [MD_XLEN-1:0] lo
);

  localparam logic [MD_CNT_W-1:0] MULT_N = MD_CNT_W'(MULT_CYCLES);
  localparam logic [MD_CNT_W-1:0] DIV_N  = MD_CNT_W'(DIV_CYCLES);

  md_state_e             state_q, state_d;
  logic [MD_CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*MD_XLEN-1:0]  res_q, res_d;
  logic                  wr_q, wr_d;
  logic [MD_XLEN-1:0]    hi_q, hi_d;
  logic [MD_XLEN-1:0]    lo_q, lo_d;

  logic [2*MD_XLEN-1:0]  prod_s;
  logic [2*MD_XLEN-1:0]  prod_u;
  logic [MD_XLEN-1:0]    quot;
  logic [MD_XLEN-1:0]    rem;
  logic                  dbz;
  logic                  accept;
  logic                  is_long_op;
  logic                  last_cycle;

  md_divider u_div (
    .dividend    (rs_val),
    .divisor     (rt_val),
    .is_signed   (md_op == MD_DIV),
    .quotient    (quot),
    .remainder   (rem),
    .div_by_zero (dbz)
  );

  always_comb begin
    prod_s     = {{MD_XLEN{rs_val[MD_XLEN-1]}}, rs_val} * {{MD_XLEN{rt_val[MD_XLEN-1]}}, rt_val};
    prod_u     = {{MD_XLEN{1'b0}}, rs_val} * {{MD_XLEN{1'b0}}, rt_val};
    accept     = start && (state_q == ST_IDLE);
    is_long_op = (md_op == MD_MULT) || (md_op == MD_MULTU) ||
                 (md_op == MD_DIV)  || (md_op == MD_DIVU);
    last_cycle = (cnt_q <= MD_CNT_W'(1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      res_q   <= '0;
      wr_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      wr_q    <= wr_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept && is_long_op) state_d = ST_RUN;
      ST_RUN:  if (last_cycle) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    res_d = res_q;
    wr_d  = wr_q;
    hi_d  = hi_q;
    lo_d  = lo_q;
    if (accept) begin
      case (md_op)
        MD_MULT:  begin res_d = prod_s;     wr_d = 1'b1; cnt_d = MULT_N; end
        MD_MULTU: begin res_d = prod_u;     wr_d = 1'b1; cnt_d = MULT_N; end
        MD_DIV,
        MD_DIVU:  begin res_d = {rem, quot}; wr_d = !dbz; cnt_d = DIV_N; end
        MD_MTHI:  hi_d = rs_val;
        MD_MTLO:  lo_d = rs_val;
        default:  ;
      endcase
    end else if (state_q == ST_RUN) begin
      cnt_d = cnt_q - 1'b1;
      // Divide-by-zero leaves wr_q clear, so HI/LO survive the full latency.
      if (last_cycle) begin
        cnt_d = '0;
        wr_d  = 1'b0;
        if (wr_q) {hi_d, lo_d} = res_q;
      end
    end
  end

  always_comb begin
    busy = (state_q == ST_RUN);
    hi   = hi_q;
    lo   = lo_q;
  end

  always @(posedge clk) begin
    if (!reset && state_q == ST_RUN)
      assert (!start) else $warning("e_stage_mdu: start while busy ignored");
  end

endmodule

// File: doc/e_stage_mdu.md
Name: e_stage_mdu

Overview:
Multiply/divide unit in the Execute stage, directly downstream of the D/E pipeline register. It consumes the forwarded rs/rt operands and the decoded MD opcode of the instruction in E, and computes MULT/MULTU/DIV/DIVU over a fixed multi-cycle latency. It owns the architectural HI/LO registers and executes MTHI/MTLO. It exposes start/busy so the hazard unit can stall dependent MD instructions in D.

Parameters:
MULT_CYCLES, 5, busy cycles for MULT/MULTU (legal range 1..15)
DIV_CYCLES, 10, busy cycles for DIV/DIVU (legal range 1..15)

Ports:
clk  in  1  single clock; all state updates on posedge clk
reset  in  1  synchronous, active-high reset
start  in  1  E-stage instruction is an MD op; sampled at posedge clk
md_op  in  3  MD operation, encodings in shared package
rs_val  in  32  forwarded rs operand (dividend / multiplicand / MTHI/MTLO source)
rt_val  in  32  forwarded rt operand (divisor / multiplier)
busy  out  1  multi-cycle operation in flight
hi  out  32  architectural HI register
lo  out  32  architectural LO register

Behaviour:
- Reset: at a posedge with reset=1: busy=0, counter=0, hi=0, lo=0, pending result discarded. Reset mid-operation aborts it; HI/LO are not written by the aborted op. Reset takes priority over start.
- Idle (busy=0), start=1 at edge k:
  - MULT: pending {hi,lo} = signed(rs)*signed(rt), full 64 bits. MULTU: unsigned 64-bit product.
  - DIV: pending lo = signed quotient truncated toward zero, hi = remainder with the sign of the dividend. DIVU: unsigned quotient and remainder.
  - At edge k, busy goes to 1 and counter loads N (MULT_CYCLES or DIV_CYCLES).
  - busy stays high for exactly N cycles.
  - At edge k+N, hi/lo take the pending values, busy returns to 0, counter returns to 0.
  - Results are visible starting in cycle k+N.
- MTHI/MTLO with start=1 while idle: hi (or lo) = rs_val at edge k. busy is not asserted and the other register is unchanged.
- Divide by zero (rt=0, DIV or DIVU): runs the full DIV_CYCLES with busy, then leaves HI/LO unchanged. The unit never traps.
- Signed overflow, DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- start=1 while busy=1: ignored entirely, including MTHI/MTLO. The hazard unit guarantees this never happens; assert in simulation.
- md_op=MD_NONE or an undefined encoding with start=1: no effect.
- Operands are captured at the start edge. Later changes to rs_val/rt_val do not affect the in-flight result.
- Hazard contract: the hazard unit stalls an MD instruction in D when (start | busy) = 1. hi/lo are read combinationally by MFHI/MFLO in E only when busy=0.
- Pending state: 64-bit result register plus a 4-bit down-counter. Compute the result at the start edge with the `*` and `/` operators; the counter only models latency.

Decomposition:
- Shared package md_pkg:
  - md_op encodings: MD_NONE=0, MD_MULT=1, MD_MULTU=2, MD_DIV=3, MD_DIVU=4, MD_MTHI=5, MD_MTLO=6.
  - Default latency constants.
- Sub-module md_divider: a purely combinational signed/unsigned quotient/remainder with the sign-fix and divide-by-zero flag. It isolates the sign rules for unit testing.
- The counter/commit FSM (IDLE, RUN) stays in e_stage_mdu.

Test Plan:
- MULT rs=0xFFFFFFFE(-2), rt=3 at edge k -> busy high for cycles k..k+4; at k+5 hi=0xFFFFFFFF, lo=0xFFFFFFFA, busy=0.
- MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF -> after 5 cycles hi=0xFFFFFFFE, lo=0x00000001.
- DIV rs=-7 (0xFFFFFFF9), rt=2 -> after 10 busy cycles lo=0xFFFFFFFD(-3), hi=0xFFFFFFFF(-1). Then DIVU same operands -> lo=0x7FFFFFFC, hi=1.
- MTHI rs=0x12345678 while idle -> hi=0x12345678 next cycle, lo unchanged, busy never asserts. Then DIV with rt=0 -> busy 10 cycles, hi/lo unchanged.
- DIV started, reset=1 at 4th busy cycle -> next edge busy=0, hi=lo=0, and no later commit. DIV 0x80000000/-1 -> lo=0x80000000, hi=0.
- MULT started, then start=1 with MTLO on the 2nd busy cycle -> ignored and the simulation assertion fires. MULT result commits unchanged.
